// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: control inputs, next-PC/instruction-memory connections and the F/D register outputs.
// Latency: none (wires only).
// Backpressure: stall is carried as a plain level; there is no handshake.
// Ports (master = fetch stage side):
//   in : stall, req, eret_d, epc, next_pc, branch_d, i_inst_rdata
//   out: pc, i_inst_addr, d_pc, d_instr, d_bd, d_exccode
interface fetch_stage_if;
  logic        stall;
  logic        req;
  logic        eret_d;
  logic [31:0] epc;
  logic [31:0] next_pc;
  logic        branch_d;
  logic [31:0] i_inst_rdata;
  logic [31:0] pc;
  logic [31:0] i_inst_addr;
  logic [31:0] d_pc;
  logic [31:0] d_instr;
  logic        d_bd;
  logic [4:0]  d_exccode;

  modport master (
    input  stall, req, eret_d, epc, next_pc, branch_d, i_inst_rdata,
    output pc, i_inst_addr, d_pc, d_instr, d_bd, d_exccode
  );

  modport slave (
    output stall, req, eret_d, epc, next_pc, branch_d, i_inst_rdata,
    input  pc, i_inst_addr, d_pc, d_instr, d_bd, d_exccode
  );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: architectural PC, I-memory address, F/D pipeline register.
// Latency: fetched word appears on d_* one clock after its address is on pc.
// Backpressure: stall freezes pc and d_*; req (exception/interrupt) overrides stall.
// Ports: clk, reset (async active-high); bus (fetch_stage_if.master) carries the
//   control inputs, next_pc, i_inst_rdata, and the pc / i_inst_addr / d_* outputs.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI    = 32'h0000_6ffc
) (
  input  logic           clk,
  input  logic           reset,
  fetch_stage_if.master  bus
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic [31:0] pc_q;
  logic [31:0] d_pc_q;
  logic [31:0] d_instr_q;
  logic        d_bd_q;
  logic [4:0]  d_exccode_q;

  // Fetch address error: misaligned or outside the text segment (unsigned compares).
  logic        f_adel;
  logic [31:0] f_instr;
  logic [4:0]  f_exccode;

  always_comb begin
    f_adel    = (pc_q[1:0] != 2'b00) || (pc_q < TEXT_LO) || (pc_q > TEXT_HI);
    f_instr   = f_adel ? 32'd0 : bus.i_inst_rdata;
    f_exccode = f_adel ? EXC_ADEL : EXC_NONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      d_pc_q      <= 32'd0;
      d_instr_q   <= 32'd0;
      d_bd_q      <= 1'b0;
      d_exccode_q <= EXC_NONE;
    end else if (bus.req) begin
      // Redirect to the handler; D gets a bubble tagged with the handler address.
      pc_q        <= HANDLER_PC;
      d_pc_q      <= HANDLER_PC;
      d_instr_q   <= 32'd0;
      d_bd_q      <= 1'b0;
      d_exccode_q <= EXC_NONE;
    end else if (bus.stall) begin
      pc_q        <= pc_q;
      d_pc_q      <= d_pc_q;
      d_instr_q   <= d_instr_q;
      d_bd_q      <= d_bd_q;
      d_exccode_q <= d_exccode_q;
    end else if (bus.eret_d) begin
      // eret has no delay slot: squash the F word, including any fetch error it carried.
      pc_q        <= bus.epc;
      d_pc_q      <= pc_q;
      d_instr_q   <= 32'd0;
      d_bd_q      <= 1'b0;
      d_exccode_q <= EXC_NONE;
    end else begin
      pc_q        <= bus.next_pc;
      d_pc_q      <= pc_q;
      d_instr_q   <= f_instr;
      d_bd_q      <= bus.branch_d;
      d_exccode_q <= f_exccode;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.i_inst_addr = pc_q;
  assign bus.d_pc        = d_pc_q;
  assign bus.d_instr     = d_instr_q;
  assign bus.d_bd        = d_bd_q;
  assign bus.d_exccode   = d_exccode_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed walk through the main scenarios, then randomized traffic
// compared every cycle against a behavioural model of the PC and F/D register.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] TEXT_LO    = 32'h0000_3000;
  localparam logic [31:0] TEXT_HI    = 32'h0000_6ffc;

  logic clk = 1'b0;
  logic reset;
  fetch_stage_if bus ();

  fetch_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory: word is its own address scrambled by a key.
  logic [31:0] mem_key = 32'd0;
  assign bus.i_inst_rdata = bus.i_inst_addr ^ mem_key;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] dpc;
    logic [31:0] dinstr;
    logic        dbd;
    logic [4:0]  dexc;
  } st_t;

  st_t m;
  int  checks   = 0;
  int  failures = 0;
  bit  chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic st_t reset_state();
    st_t s;
    s.pc = RESET_PC; s.dpc = 32'd0; s.dinstr = 32'd0; s.dbd = 1'b0; s.dexc = 5'd0;
    return s;
  endfunction

  // What the stage must hold after the next edge, given current inputs.
  function automatic st_t model_next(input st_t s);
    st_t n;
    bit  bad;
    n   = s;
    bad = (s.pc % 4 != 0) || (s.pc < TEXT_LO) || (s.pc > TEXT_HI);
    if (bus.req) begin
      n.pc = HANDLER_PC; n.dpc = HANDLER_PC; n.dinstr = 0; n.dbd = 0; n.dexc = 0;
    end else if (bus.stall) begin
      n = s;
    end else if (bus.eret_d) begin
      n.pc = bus.epc; n.dpc = s.pc; n.dinstr = 0; n.dbd = 0; n.dexc = 0;
    end else begin
      n.pc     = bus.next_pc;
      n.dpc    = s.pc;
      n.dinstr = bad ? 32'd0 : (s.pc ^ mem_key);
      n.dexc   = bad ? 5'd4 : 5'd0;
      n.dbd    = bus.branch_d;
    end
    return n;
  endfunction

  // Compare process: outputs vs model, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc",          bus.pc,          m.pc);
      chk("i_inst_addr", bus.i_inst_addr, m.pc);
      chk("d_pc",        bus.d_pc,        m.dpc);
      chk("d_instr",     bus.d_instr,     m.dinstr);
      chk("d_bd",        {31'd0, bus.d_bd},      {31'd0, m.dbd});
      chk("d_exccode",   {27'd0, bus.d_exccode}, {27'd0, m.dexc});
    end
  end

  task automatic step();
    st_t n;
    n = model_next(m);
    @(posedge clk);
    m = n;
    #1;
  endtask

  task automatic nx4();
    bus.next_pc = m.pc + 32'd4;
  endtask

  task automatic clear_ctl();
    bus.stall = 0; bus.req = 0; bus.eret_d = 0; bus.branch_d = 0; bus.epc = 32'd0;
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0: return TEXT_HI;
      1: return TEXT_HI + 32'd4;
      2: return TEXT_LO;
      3: return TEXT_LO - 32'd4;
      4: return TEXT_LO + ($urandom_range(0, 32'h0fff) * 4) + $urandom_range(1, 3);
      5: return $urandom;
      default: return TEXT_LO + ($urandom_range(0, 32'h0fff) * 4);
    endcase
  endfunction

  initial begin
    clear_ctl();
    bus.next_pc = 32'd0;
    reset = 1'b1;
    m = reset_state();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    chk_en = 1'b1;

    // Reset values and sequential fetch.
    chk("rst_pc", bus.pc, 32'h3000);
    chk("rst_d_pc", bus.d_pc, 32'h0);
    chk("rst_d_instr", bus.d_instr, 32'h0);
    nx4(); step();
    chk("seq1_pc", bus.pc, 32'h3004);
    chk("seq1_d_instr", bus.d_instr, 32'h3000);
    nx4(); step();
    chk("seq2_pc", bus.pc, 32'h3008);
    chk("seq2_d_pc", bus.d_pc, 32'h3004);

    // Two-cycle stall.
    bus.stall = 1; nx4(); step(); step();
    chk("stall_pc", bus.pc, 32'h3008);
    chk("stall_d_pc", bus.d_pc, 32'h3004);
    bus.stall = 0; nx4(); step();
    chk("unstall_pc", bus.pc, 32'h300c);
    chk("unstall_d_pc", bus.d_pc, 32'h3008);
    nx4(); step();

    // Delay-slot tagging at pc 3010.
    bus.branch_d = 1; nx4(); step();
    chk("bd_d_pc", bus.d_pc, 32'h3010);
    chk("bd_set", {31'd0, bus.d_bd}, 32'd1);
    bus.branch_d = 0; nx4(); step();
    chk("bd_clr", {31'd0, bus.d_bd}, 32'd0);

    // Fetch address errors: misaligned, below and above the text segment.
    bus.next_pc = 32'h3002; step();
    bus.next_pc = 32'h2ffc; step();
    chk("adel_mis_d_pc", bus.d_pc, 32'h3002);
    chk("adel_mis_exc", {27'd0, bus.d_exccode}, 32'd4);
    chk("adel_mis_instr", bus.d_instr, 32'h0);
    bus.next_pc = 32'h7000; step();
    chk("adel_lo_d_pc", bus.d_pc, 32'h2ffc);
    chk("adel_lo_exc", {27'd0, bus.d_exccode}, 32'd4);
    // eret while F holds a bad pc: squashed, no error reported.
    bus.eret_d = 1; bus.epc = 32'h3020; step();
    chk("eret_bad_d_pc", bus.d_pc, 32'h7000);
    chk("eret_bad_exc", {27'd0, bus.d_exccode}, 32'd0);
    chk("eret_bad_pc", bus.pc, 32'h3020);

    // eret at pc 3020 to epc 3040.
    bus.epc = 32'h3040; step();
    chk("eret_d_pc", bus.d_pc, 32'h3020);
    chk("eret_d_instr", bus.d_instr, 32'h0);
    chk("eret_pc", bus.pc, 32'h3040);
    // eret under stall waits for the stall to drop.
    bus.stall = 1; bus.epc = 32'h3080; step(); step();
    chk("eret_stall_pc", bus.pc, 32'h3040);
    chk("eret_stall_d_pc", bus.d_pc, 32'h3020);
    bus.stall = 0; step();
    chk("eret_rel_pc", bus.pc, 32'h3080);
    chk("eret_rel_d_pc", bus.d_pc, 32'h3040);

    // req beats stall and eret.
    bus.req = 1; bus.stall = 1; bus.eret_d = 1; step();
    chk("req_pc", bus.pc, 32'h4180);
    chk("req_d_pc", bus.d_pc, 32'h4180);
    chk("req_d_instr", bus.d_instr, 32'h0);
    clear_ctl(); nx4(); step();
    chk("handler_d_instr", bus.d_instr, 32'h4180);

    // Asynchronous reset mid-cycle.
    #1 reset = 1'b1;
    #1;
    chk("async_rst_pc", bus.pc, 32'h3000);
    chk("async_rst_d_pc", bus.d_pc, 32'h0);
    m = reset_state();
    reset = 1'b0;
    nx4(); step();
    chk("post_rst_d_pc", bus.d_pc, 32'h3000);

    // Randomized traffic.
    mem_key = $urandom;
    for (int i = 0; i < 3000; i++) begin
      bus.stall    = ($urandom_range(0, 3) == 0);
      bus.req      = ($urandom_range(0, 15) == 0);
      bus.eret_d   = ($urandom_range(0, 9) == 0);
      bus.branch_d = ($urandom_range(0, 3) == 0);
      bus.epc      = rand_addr();
      if ($urandom_range(0, 4) == 0) bus.next_pc = rand_addr();
      else nx4();
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        #1;
        m = reset_state();
        #1 reset = 1'b0;
      end
      step();
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline: holds the architectural PC, drives the instruction-memory address, and registers the fetched word into the F/D pipeline register. It takes the next-PC value computed by the next-PC logic and feeds its own current PC back to that logic. It also handles stalls, exception/interrupt redirect to the handler, `eret` redirect to EPC, fetch address-error detection and delay-slot tagging.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000, PC value after reset.
- `HANDLER_PC`, 32'h0000_4180, exception/interrupt entry.
- `TEXT_LO`, 32'h0000_3000, lowest legal fetch address.
- `TEXT_HI`, 32'h0000_6ffc, highest legal fetch address.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `stall` in 1: hazard stall; hold PC and F/D register.
- `req` in 1: exception/interrupt taken this cycle (from CP0).
- `eret_d` in 1: instruction in D is `eret`.
- `epc` in 32: return address from CP0.
- `next_pc` in 32: sequential/branch/jump target from next-PC logic.
- `branch_d` in 1: instruction in D is a branch or jump, so the F instruction is a delay slot.
- `i_inst_rdata` in 32: instruction word at `i_inst_addr` (combinational read).
- `pc` out 32: current F-stage PC, fed to next-PC logic.
- `i_inst_addr` out 32: equals `pc`.
- `d_pc` out 32: PC of the D-stage instruction.
- `d_instr` out 32: D-stage instruction word.
- `d_bd` out 1: D-stage instruction is in a delay slot.
- `d_exccode` out 5: fetch exception code; 0 = none, 4 = AdEL.

## Operation
- F-stage fetch error `f_adel`: `pc[1:0] != 0`, or `pc < TEXT_LO`, or `pc > TEXT_HI`. Comparisons are unsigned.
- On a fetch error, the fetched word is replaced by 0 (nop) and the exccode is 4. Otherwise the word is `i_inst_rdata` and the exccode is 0.
- Update priority at each edge, highest first:
  - `reset`: PC = `RESET_PC`; all D outputs = 0.
  - `req`: PC = `HANDLER_PC`. D loads a bubble: instr 0, exccode 0, bd 0, pc = `HANDLER_PC`. `req` overrides `stall`.
  - `stall`: PC and all D registers hold.
  - `eret_d`: PC = `epc`. The F instruction is squashed: D gets instr 0, exccode 0, bd 0, pc = current `pc`. A fetch error on a squashed slot is never reported.
  - Normal: PC = `next_pc`. D gets pc = `pc`, the instr/exccode above, and bd = `branch_d`.
- No arithmetic is performed in this block; `pc + 4` / `pc + 8` come from next-PC logic.
- `eret` has no delay slot; squashing the F word implements this.

## Timing
- `i_inst_addr`/`pc` change only on `clk` rising edge or asynchronously on `reset`.
- Fetch-to-D latency is 1 cycle: the word addressed in cycle N appears on `d_*` in cycle N+1.
- `req` and `eret_d` take effect on the edge at which they are sampled high. The handler or EPC fetch occurs in the following cycle.
- `stall` held for k cycles freezes `pc` and `d_*` for k edges. The first non-stalled edge resumes with the held values.
- `eret_d` together with `stall`: no redirect. The `eret` stays in D and redirects on the first non-stalled edge.
- `req` together with `eret_d`: `req` wins; PC = `HANDLER_PC`.
- Reset asserted mid-operation: outputs go immediately to reset values regardless of the clock. The first fetch after deassertion is at `RESET_PC`.
- Reset values: `pc` = `i_inst_addr` = 32'h3000; `d_pc` = 0, `d_instr` = 0, `d_bd` = 0, `d_exccode` = 0.

## Test plan
- Reset, then run 3 cycles with `next_pc` = `pc + 4` and memory returning `{addr}` -> `pc` goes 3000, 3004, 3008; `d_pc`/`d_instr` lag by 1 cycle; all exccode 0.
- `stall` high for 2 cycles at `pc` = 3008 -> `pc` stays 3008 and `d_pc` stays 3004 for 2 edges, then advances to 300c / 3008.
- `branch_d` = 1 while `pc` = 3010 -> the next edge gives `d_pc` = 3010, `d_bd` = 1; the following instruction gets `d_bd` = 0.
- `next_pc` = 3002, then 2ffc -> each D entry shows `d_instr` = 0, `d_exccode` = 4, `d_pc` = the bad address; asserting `eret_d` with a bad `pc` yields exccode 0.
- `eret_d` = 1 with `epc` = 3040 and `pc` = 3020 -> `d_instr` = 0, `d_pc` = 3020, and the next `pc` = 3040. Repeat with `stall` = 1 -> no change until `stall` drops.
- `req` = 1 together with `stall` = 1 and `eret_d` = 1 -> `pc` = 4180, `d_pc` = 4180, `d_instr` = 0. Asserting `reset` mid-cycle -> `pc` = 3000 before the next edge.
